adder_tree_burst_scheduler: RTL

Two-requester scheduler that shares a single accumulating adder between two operand streams. Each requester submits a burst of exactly N_OPERANDS unsigned operands. A round-robin arbiter grants the adder to one requester for a whole burst. The block returns the full-precision burst sum, tagged with the requester id. It sits in front of the adder-tree datapath and serves the cases where a full parallel tree is too expensive.

---
 rtl/adder_sched_pkg.sv | 20 ++
 rtl/adder_sched_rr_arb.sv | 35 +++
 rtl/adder_tree_burst_scheduler.sv | 117 +++++++++++
 3 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the burst-accumulating adder scheduler.
package adder_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic req_id_t;

    localparam int unsigned NUM_REQ = 2;

    // Result width that holds N_OPERANDS maximum-value operands without overflow.
    function automatic int unsigned sum_width(input int unsigned width,
                                              input int unsigned n_operands);
        return width + $clog2(n_operands);
    endfunction

endpackage

// File: rtl/adder_sched_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module adder_sched_rr_arb
    import adder_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output req_id_t            grant_id,
    output logic               grant_valid
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        if (&req) begin
            grant_id = ptr_q;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
        ptr_d = advance ? ~grant_id : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_tree_burst_scheduler.sv
// Shares one accumulating adder between two requesters, one whole burst at a time,
// and returns the full-precision burst sum tagged with the owning requester.
module adder_tree_burst_scheduler
    import adder_sched_pkg::*;
#(
    parameter int unsigned WIDTH      = 14,
    parameter int unsigned N_OPERANDS = 8,
    parameter int unsigned SUM_WIDTH  = sum_width(WIDTH, N_OPERANDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [WIDTH-1:0]     req_data0,
    input  logic [WIDTH-1:0]     req_data1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_WIDTH-1:0] out_sum,
    output logic                 out_id,
    output logic                 busy
);

    localparam int unsigned       CNT_W    = $clog2(N_OPERANDS);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_OPERANDS - 1);

    state_e               state_q, state_d;
    logic [SUM_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    req_id_t              grant_q, grant_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   arb_req;
    logic                 arb_advance;
    req_id_t              arb_grant_id;
    logic                 arb_grant_valid;
    logic [WIDTH-1:0]     operand;
    logic                 accept;

    // In DONE the arbiter sees only the owner, so advancing moves the pointer past it.
    always_comb begin
        arb_req = (state_q == DONE) ? {grant_q, ~grant_q} : req_valid;
    end

    adder_sched_rr_arb u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (arb_req),
        .advance     (arb_advance),
        .grant_id    (arb_grant_id),
        .grant_valid (arb_grant_valid)
    );

    always_comb begin
        operand = grant_q ? req_data1 : req_data0;
        accept  = (state_q == ACCUM) && req_valid[grant_q];

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        arb_advance = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_grant_valid) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    grant_d = arb_grant_id;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + SUM_WIDTH'(operand);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    arb_advance = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready = (state_q == ACCUM) ? {grant_q, ~grant_q} : '0;
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_id    = grant_q;
    assign busy      = busy_q;

endmodule
